// File: rtl/addsub_seq_ctrl.sv
// Nibble-serial 16-bit signed saturating add/subtract sequencer.
// One 4-bit slice is reused across NIBBLES cycles with a registered carry between nibbles.
module addsub_seq_ctrl #(
    parameter int NIBBLES = 4,
    localparam int W = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         flag_z,
    output logic         flag_v,
    output logic         flag_n
);

    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic {
        IDLE,
        CALC
    } state_t;

    state_t state, state_next;

    logic [W-1:0]  a_reg, b_reg, psum;
    logic          sub_reg;
    logic          carry;
    logic [CW-1:0] cnt;

    logic          load, step, finish, last;
    logic [3:0]    a_nib, b_nib;
    logic [4:0]    slice;
    logic          carry_into_msb, overflow;
    logic [W-1:0]  raw_sum, sat_sum;

    assign last = (cnt == CW'(NIBBLES - 1));
    assign busy = (state == CALC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                step = 1'b1;
                if (last) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Select the current nibble of each operand; B is inverted for subtraction
    // so that with carry-in preset to 1 the slice computes A + ~B + 1.
    always_comb begin
        a_nib = 4'h0;
        b_nib = 4'h0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (cnt == CW'(i)) begin
                a_nib = a_reg[i*4 +: 4];
                b_nib = b_reg[i*4 +: 4];
            end
        end
        b_nib = b_nib ^ {4{sub_reg}};
    end

    assign slice = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry};

    // Sum bit 3 is a3 ^ b3 ^ c3, so the carry into the MSB falls out of the sum.
    assign carry_into_msb = a_nib[3] ^ b_nib[3] ^ slice[3];
    assign overflow       = carry_into_msb ^ slice[4];

    always_comb begin
        raw_sum = psum;
        raw_sum[(NIBBLES-1)*4 +: 4] = slice[3:0];
        if (overflow) begin
            sat_sum = a_reg[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            sat_sum = raw_sum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg   <= '0;
            b_reg   <= '0;
            sub_reg <= 1'b0;
            psum    <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            done    <= 1'b0;
            result  <= '0;
            flag_z  <= 1'b0;
            flag_v  <= 1'b0;
            flag_n  <= 1'b0;
        end else begin
            done <= finish;
            if (load) begin
                a_reg   <= a;
                b_reg   <= b;
                sub_reg <= sub;
                carry   <= sub;
                cnt     <= '0;
            end else if (step) begin
                for (int i = 0; i < NIBBLES; i++) begin
                    if (cnt == CW'(i)) begin
                        psum[i*4 +: 4] <= slice[3:0];
                    end
                end
                carry <= slice[4];
                cnt   <= cnt + 1'b1;
            end
            if (finish) begin
                result <= sat_sum;
                flag_v <= overflow;
                flag_z <= (sat_sum == '0);
                flag_n <= sat_sum[W-1];
            end
        end
    end

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Self-checking bench for addsub_seq_ctrl: directed vector table, handshake and
// reset corner cases, and a randomized run against a clamped-integer reference model.
module tb_addsub_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        flag_z;
    logic        flag_v;
    logic        flag_n;

    int assert_count = 0;
    int fail_count   = 0;

    addsub_seq_ctrl #(.NIBBLES(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .sub    (sub),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .flag_z (flag_z),
        .flag_v (flag_v),
        .flag_n (flag_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        sub;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        z;
        logic        v;
        logic        n;
    } vec_t;

    vec_t vectors[10];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Pulse start for one edge, scramble inputs afterwards, then wait (bounded)
    // for done. Returns in the done cycle with the cycles counted since acceptance.
    task automatic applyStimulus(input logic s, input logic [15:0] aa, input logic [15:0] bb,
                                 output int lat, output logic busy_after);
        @(posedge clk); #1;
        start = 1'b1;
        sub   = s;
        a     = aa;
        b     = bb;
        @(posedge clk); #1;
        busy_after = busy;
        start = 1'b0;
        sub   = 1'($urandom);
        a     = 16'($urandom);
        b     = 16'($urandom);
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    function automatic void refModel(input logic s, input logic [15:0] aa, input logic [15:0] bb,
                                     output logic [15:0] r, output logic v);
        int sa;
        int sb;
        int raw;
        int clamped;
        sa  = int'($signed(aa));
        sb  = int'($signed(bb));
        raw = s ? (sa - sb) : (sa + sb);
        if (raw > 32767)
            clamped = 32767;
        else if (raw < -32768)
            clamped = -32768;
        else
            clamped = raw;
        r = clamped[15:0];
        v = (raw != clamped);
    endfunction

    initial begin
        int          lat;
        int          cycles;
        int          done_seen;
        logic        busy_after;
        logic [15:0] exp_r;
        logic        exp_v;
        logic        rs;
        logic [15:0] ra, rb;

        vectors[0] = '{"carry_1234_0fcd", 1'b0, 16'h1234, 16'h0FCD, 16'h2201, 1'b0, 1'b0, 1'b0};
        vectors[1] = '{"carry_00ff_0001", 1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0};
        vectors[2] = '{"sat_7fff_p1",     1'b0, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0};
        vectors[3] = '{"sat_8000_m1",     1'b1, 16'h8000, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b1};
        vectors[4] = '{"sat_8000_p8000",  1'b0, 16'h8000, 16'h8000, 16'h8000, 1'b0, 1'b1, 1'b1};
        vectors[5] = '{"zero_5_m5",       1'b1, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b0};
        vectors[6] = '{"neg_3_m5",        1'b1, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0, 1'b1};
        vectors[7] = '{"zero_0_p0",       1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0};
        vectors[8] = '{"sat_0_m8000",     1'b1, 16'h0000, 16'h8000, 16'h7FFF, 1'b0, 1'b1, 1'b0};
        vectors[9] = '{"neg_ffff_pffff",  1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0, 1'b0, 1'b1};

        rst_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        a     = 16'h0000;
        b     = 16'h0000;

        #12;
        checkOutput("reset_busy",   32'(busy),   32'h0);
        checkOutput("reset_done",   32'(done),   32'h0);
        checkOutput("reset_result", 32'(result), 32'h0);
        checkOutput("reset_z",      32'(flag_z), 32'h0);
        checkOutput("reset_v",      32'(flag_v), 32'h0);
        checkOutput("reset_n",      32'(flag_n), 32'h0);
        #5 rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vectors[i].sub, vectors[i].a, vectors[i].b, lat, busy_after);
            checkOutput({vectors[i].name, "_busy"},    32'(busy_after),    32'h1);
            checkOutput({vectors[i].name, "_latency"}, 32'(lat),           32'd4);
            checkOutput({vectors[i].name, "_result"},  32'(result),        32'(vectors[i].res));
            checkOutput({vectors[i].name, "_z"},       32'(flag_z),        32'(vectors[i].z));
            checkOutput({vectors[i].name, "_v"},       32'(flag_v),        32'(vectors[i].v));
            checkOutput({vectors[i].name, "_n"},       32'(flag_n),        32'(vectors[i].n));
        end

        // Asynchronous reset two cycles into CALC must discard the operation.
        @(posedge clk); #1;
        start = 1'b1; sub = 1'b0; a = 16'h1234; b = 16'h0001;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy",   32'(busy),   32'h0);
        checkOutput("midrst_done",   32'(done),   32'h0);
        checkOutput("midrst_result", 32'(result), 32'h0);
        checkOutput("midrst_z",      32'(flag_z), 32'h0);
        checkOutput("midrst_v",      32'(flag_v), 32'h0);
        checkOutput("midrst_n",      32'(flag_n), 32'h0);
        @(posedge clk); #3 rst_n = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (done || busy) done_seen++;
        end
        checkOutput("midrst_no_done", 32'(done_seen), 32'h0);
        applyStimulus(1'b0, 16'h0001, 16'h0001, lat, busy_after);
        checkOutput("postrst_latency", 32'(lat),    32'd4);
        checkOutput("postrst_result",  32'(result), 32'h0002);

        // start held high during the whole operation: only the first is performed.
        @(posedge clk); #1;
        start = 1'b1; sub = 1'b0; a = 16'h0010; b = 16'h0020;
        @(posedge clk); #1;
        done_seen = 0;
        cycles = 0;
        while (busy && cycles < 20) begin
            a = 16'($urandom);
            b = 16'($urandom);
            sub = 1'($urandom);
            @(posedge clk); #1;
            cycles++;
            if (done) begin
                done_seen++;
                start = 1'b0;
            end
        end
        start = 1'b0;
        checkOutput("hold_result", 32'(result), 32'h0030);
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (done) done_seen++;
            if (busy) done_seen += 100;
        end
        checkOutput("hold_one_done", 32'(done_seen), 32'h1);
        checkOutput("hold_result_kept", 32'(result), 32'h0030);

        // start asserted in the done cycle is accepted immediately.
        applyStimulus(1'b0, 16'h0100, 16'h0200, lat, busy_after);
        checkOutput("b2b_first_done", 32'(done),   32'h1);
        checkOutput("b2b_first",      32'(result), 32'h0300);
        start = 1'b1; sub = 1'b1; a = 16'h0050; b = 16'h0060;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("b2b_busy", 32'(busy), 32'h1);
        cycles = 1;
        while (!done && cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
        end
        checkOutput("b2b_spacing", 32'(cycles), 32'd5);
        checkOutput("b2b_second",  32'(result), 32'hFFF0);
        checkOutput("b2b_n",       32'(flag_n), 32'h1);

        for (int i = 0; i < 1000; i++) begin
            rs = 1'($urandom);
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i % 4 == 0) ra = {ra[15], {15{~ra[15]}}};
            refModel(rs, ra, rb, exp_r, exp_v);
            applyStimulus(rs, ra, rb, lat, busy_after);
            checkOutput("rand_latency", 32'(lat),    32'd4);
            checkOutput("rand_result",  32'(result), 32'(exp_r));
            checkOutput("rand_v",       32'(flag_v), 32'(exp_v));
            checkOutput("rand_z",       32'(flag_z), 32'(exp_r == 16'h0000));
            checkOutput("rand_n",       32'(flag_n), 32'(exp_r[15]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
